// File: rtl/ascon_permutation_core.sv
`default_nettype none
// ============================================================================
// Module   : ascon_permutation_core
// Purpose  : Iterative Ascon permutation. Applies 12, 8 or 6 rounds to a
//            320-bit state. Each round is constant addition, the 5-bit S-box
//            and linear diffusion. UNROLL rounds are evaluated per clock.
// Ports    : clock_i / reset_i - clock and synchronous active-high reset
//            start_i, mode_i   - start request and round select (00=12,
//                                01=8, 10=6, 11=12), taken when ready_o=1
//            state_i           - input state, lane k = x_k
//            ready_o           - high in IDLE and DONE
//            done_o            - one-cycle completion pulse
//            state_o           - state register, final from done_o onward
// Revision : 1.0 - initial release
// ============================================================================
module ascon_permutation_core #(
    parameter int UNROLL = 1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic [4:0][63:0] state_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [4:0][63:0] state_o
);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_run  = 2'd1;
    localparam logic [1:0] c_s_done = 2'd2;
    localparam logic [3:0] c_step   = 4'(UNROLL);
    localparam logic [3:0] c_last   = 4'd12;

    generate
        if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
            $error("ascon_permutation_core: UNROLL must be 1 or 2");
        end
    endgenerate

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One full round at counter value i. The S-box is the bitsliced form:
    // every 64-bit lane operation processes all 64 columns at once.
    function automatic logic [4:0][63:0] ascon_round(input logic [4:0][63:0] s,
                                                     input logic [3:0]       i);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'd0, 4'hF - i, i};
        x3 = s[3];
        x4 = s[4];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    logic [1:0]       r_fsm;
    logic [3:0]       r_cnt;
    logic [4:0][63:0] r_state;

    logic [4:0][63:0] w_r1;
    logic [4:0][63:0] w_round_out;
    logic [3:0]       w_cnt_next;
    logic [3:0]       w_load_cnt;

    assign w_r1       = ascon_round(r_state, r_cnt);
    assign w_cnt_next = r_cnt + c_step;

    // The counter always ends at 12, so shorter permutations simply start
    // later in the constant sequence.
    always_comb begin
        w_load_cnt = 4'd0;
        case (mode_i)
            2'b01:   w_load_cnt = 4'd4;
            2'b10:   w_load_cnt = 4'd6;
            default: w_load_cnt = 4'd0;
        endcase
    end

    generate
        if (UNROLL == 2) begin : g_two_rounds
            assign w_round_out = ascon_round(w_r1, r_cnt + 4'd1);
        end else begin : g_one_round
            assign w_round_out = w_r1;
        end
    endgenerate

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_fsm   <= c_s_idle;
            r_cnt   <= 4'd0;
            r_state <= '0;
        end else begin
            case (r_fsm)
                // DONE accepts a new start exactly like IDLE, so operations
                // can be issued back to back without a bubble.
                c_s_idle, c_s_done: begin
                    if (start_i) begin
                        r_state <= state_i;
                        r_cnt   <= w_load_cnt;
                        r_fsm   <= c_s_run;
                    end else begin
                        r_fsm   <= c_s_idle;
                    end
                end
                c_s_run: begin
                    r_state <= w_round_out;
                    r_cnt   <= w_cnt_next;
                    if (w_cnt_next == c_last) begin
                        r_fsm <= c_s_done;
                    end
                end
                default: r_fsm <= c_s_idle;
            endcase
        end
    end

    assign ready_o = (r_fsm == c_s_idle) || (r_fsm == c_s_done);
    assign done_o  = (r_fsm == c_s_done);
    assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ascon_permutation_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_ascon_permutation_core
// Purpose  : Scoreboard bench for ascon_permutation_core. One instance per
//            UNROLL value; stimulus pushes expected results and due cycles,
//            a negedge monitor pops and compares on each done_o.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_permutation_core;

    typedef logic [4:0][63:0] st_t;
    typedef struct {
        int  due;
        int  n;
        st_t exp;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       s1, s2;
    logic [1:0] mode;
    st_t        sin;
    logic       rdy1, done1, rdy2, done2;
    st_t        so1, so2;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    item_t q1[$];
    item_t q2[$];

    logic [4:0] SBOX [32] = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                              5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                              5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                              5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
    int ROTA [5] = '{19, 61, 1, 10, 7};
    int ROTB [5] = '{28, 39, 6, 17, 41};

    ascon_permutation_core #(.UNROLL(1)) u1 (
        .clock_i(clk), .reset_i(rst), .start_i(s1), .mode_i(mode), .state_i(sin),
        .ready_o(rdy1), .done_o(done1), .state_o(so1)
    );
    ascon_permutation_core #(.UNROLL(2)) u2 (
        .clock_i(clk), .reset_i(rst), .start_i(s2), .mode_i(mode), .state_i(sin),
        .ready_o(rdy2), .done_o(done2), .state_o(so2)
    );

    function automatic int nrounds(input logic [1:0] m);
        return (m == 2'b01) ? 8 : (m == 2'b10) ? 6 : 12;
    endfunction

    // Reference: per-column table lookup and per-bit rotation indexing.
    function automatic st_t ref_perm(input st_t s_in, input logic [1:0] m);
        st_t s, t;
        logic [4:0] col, o;
        logic [63:0] y;
        s = s_in;
        for (int r = 12 - nrounds(m); r < 12; r++) begin
            s[2][7:0] = s[2][7:0] ^ 8'((15 - r) * 16 + r);
            for (int j = 0; j < 64; j++) begin
                col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
                o = SBOX[col];
                for (int k = 0; k < 5; k++) t[k][j] = o[4-k];
            end
            for (int k = 0; k < 5; k++) begin
                for (int j = 0; j < 64; j++)
                    y[j] = t[k][j] ^ t[k][(j + ROTA[k]) % 64] ^ t[k][(j + ROTB[k]) % 64];
                s[k] = y;
            end
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [319:0] got, input logic [319:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic mon_step(input int w, input logic rdy, input logic dn, input st_t so);
        item_t it;
        bit    have;
        have = (w == 1) ? (q1.size() != 0) : (q2.size() != 0);
        if (have) it = (w == 1) ? q1[0] : q2[0];
        if (have && cyc >= it.due - it.n && cyc < it.due) begin
            total++;
            if (rdy !== 1'b0) begin
                bad++;
                $display("FAIL ready_in_run u%0d cyc=%0d got=%b want=0", w, cyc, rdy);
            end
        end
        if (dn === 1'b1) begin
            total++;
            if (!have) begin
                bad++;
                $display("FAIL unexpected_done u%0d cyc=%0d got=1 want=0", w, cyc);
            end else begin
                if (w == 1) void'(q1.pop_front()); else void'(q2.pop_front());
                if (cyc != it.due || so !== it.exp) begin
                    bad++;
                    $display("FAIL result u%0d cyc=%0d due=%0d got=%h want=%h",
                             w, cyc, it.due, so, it.exp);
                end
            end
        end else if (have && cyc >= it.due) begin
            total++;
            bad++;
            $display("FAIL missing_done u%0d cyc=%0d got=0 want=1 at %0d", w, cyc, it.due);
            if (w == 1) void'(q1.pop_front()); else void'(q2.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_step(1, rdy1, done1, so1);
            mon_step(2, rdy2, done2, so2);
        end
    end

    task automatic wait_ready(input int w, output bit ok);
        int t;
        t = 0;
        while (((w == 1) ? rdy1 : rdy2) !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        ok = (t < 200);
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout u%0d got=0 want=1", w);
        end
    endtask

    // Called at posedge+1; the start is taken on the next edge.
    task automatic issue(input int w, input logic [1:0] m, input st_t s, input int hold);
        item_t it;
        bit    ok;
        wait_ready(w, ok);
        if (!ok) return;
        mode   = m;
        sin    = s;
        it.n   = nrounds(m) / ((w == 1) ? 1 : 2);
        it.due = cyc + 1 + it.n;
        it.exp = ref_perm(s, m);
        if (w == 1) begin q1.push_back(it); s1 = 1'b1; end
        else        begin q2.push_back(it); s2 = 1'b1; end
        repeat (hold) begin @(posedge clk); #1; end
        s1 = 1'b0;
        s2 = 1'b0;
    endtask

    st_t zero_st, vec_b;
    logic [7:0] rc_exp [8] = '{8'hB4, 8'hA5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

    initial begin
        bit ok;
        int d1, t;
        logic [3:0] c;
        zero_st = '0;
        for (int k = 0; k < 5; k++) vec_b[k] = 64'h0123456789ABCDEF ^ 64'(k);
        rst = 1'b1; s1 = 1'b0; s2 = 1'b0; mode = 2'b00; sin = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready1", 320'(rdy1), 320'(1));
        chk("reset_done1",  320'(done1), 320'(0));
        chk("reset_state1", so1, '0);
        chk("reset_ready2", 320'(rdy2), 320'(1));
        rst = 1'b0;

        // Reset during a run: no done, registers cleared.
        issue(1, 2'b00, vec_b, 1);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        q1.delete();
        q2.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrun_reset_ready", 320'(rdy1), 320'(1));
        chk("midrun_reset_done",  320'(done1), 320'(0));
        chk("midrun_reset_state", so1, '0);
        repeat (15) begin @(posedge clk); #1; end

        // Golden vectors and latency, all modes, both UNROLL builds.
        for (int m = 0; m < 4; m++) begin
            issue(1, 2'(m), zero_st, 1);
            issue(2, 2'(m), zero_st, 1);
            issue(1, 2'(m), vec_b, 1);
            issue(2, 2'(m), vec_b, 1);
        end

        // Back-to-back start in the DONE cycle.
        wait_ready(1, ok);
        issue(1, 2'b00, vec_b, 1);
        d1 = q1[0].due;
        wait_ready(1, ok);
        total++;
        if (cyc != d1) begin
            bad++;
            $display("FAIL b2b_accept_cycle got=%0d want=%0d", cyc, d1);
        end
        issue(1, 2'b10, ~vec_b, 1);

        // start held high through RUN: exactly one operation.
        issue(1, 2'b10, vec_b, 6);

        // Round constants for an 8-round run.
        issue(1, 2'b01, zero_st, 1);
        for (int j = 0; j < 8; j++) begin
            c = u1.r_cnt;
            chk($sformatf("round_const_%0d", j), 320'({4'hF - c, c}), 320'(rc_exp[j]));
            @(posedge clk); #1;
        end

        t = 0;
        while ((q1.size() != 0 || q2.size() != 0) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        total++;
        if (t >= 300) begin
            bad++;
            $display("FAIL drain_timeout got=%0d/%0d want=0/0", q1.size(), q2.size());
        end
        repeat (20) begin @(posedge clk); #1; end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ascon_permutation_core.md
Name: ascon_permutation_core

Overview:
Iterative Ascon permutation engine that applies p^a / p^b rounds to a 320-bit type_state (ascon_pack). Each round is round-constant addition, 5-bit S-box substitution and linear diffusion.
- The round count is selected per operation (12/8/6).
- UNROLL rounds are computed per clock, trading area for latency.
- Sits between the Ascon mode FSM (init/AD/text/finalisation) and the state register file, with a start/done handshake.

Parameters:
UNROLL, 1, rounds evaluated per clock cycle; legal values 1 or 2; any other value is a compile-time error.

Ports:
clock_i  input  1  system clock, rising edge.
reset_i  input  1  synchronous, active-high reset.
start_i  input  1  start request; accepted only when ready_o=1.
mode_i  input  2  round select, sampled with accepted start: 00=12 rounds, 01=8 rounds, 10=6 rounds, 11=reserved, treated as 12.
state_i  input  type_state (5x64)  permutation input, sampled with accepted start.
ready_o  output  1  high in IDLE and DONE.
done_o  output  1  one-cycle pulse: permutation complete.
state_o  output  type_state (5x64)  internal state register. Valid from the done_o cycle until the next accepted start.

Behaviour:
- Clocking: one clock, clock_i. Reset is synchronous, active-high on reset_i.
- Reset (wins over everything, including mid-run):
  - FSM=IDLE, state register=0, round counter=0.
  - done_o=0, ready_o=1, state_o=0.
  - Any in-flight operation is discarded with no done_o.
- FSM states IDLE, RUN, DONE:
  - IDLE: start_i=1 at an edge loads state_i and sets counter to 12-R (R = selected rounds); next state RUN. Otherwise remain in IDLE.
  - RUN: every edge applies UNROLL rounds to the register and adds UNROLL to the counter. When the post-update counter is 12, next state is DONE. start_i is ignored in RUN; there is no queuing.
  - DONE: done_o=1 for exactly this cycle. start_i=1 behaves exactly as in IDLE (back-to-back start, no idle bubble). Otherwise next state IDLE.
- Latency: start accepted at edge k → register holds the final state after edge k+N, with N=R/UNROLL. done_o is high in the cycle following edge k+N.
  - UNROLL=1: N = 12 / 8 / 6.
  - UNROLL=2: N = 6 / 4 / 3.
- Round i (counter value i, 0..11):
  - Constant addition: x2[7:0] ^= {4'hF - i[3:0], i[3:0]}. This gives 0xF0 for i=0, 0x4B for i=11. x0, x1, x3, x4 are unchanged.
  - Substitution: for each bit j in 0..63, form the 5-bit column {x0[j],x1[j],x2[j],x3[j],x4[j]}, x0 as MSB, and map it through the S-box.
  - S-box table (input 0..31): 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17.
  - Diffusion: xk ^= ROR(xk,a) ^ ROR(xk,b). Rotation pairs (a,b): x0 (19,28), x1 (61,39), x2 (1,6), x3 (10,17), x4 (7,41).
- UNROLL=2: two chained rounds per cycle, using constants for counters i and i+1.
- Counter width: 4 bits; it never exceeds 12.
- All legal R are even, so R is always divisible by UNROLL.
- state_o in RUN shows intermediate round values; consumers use it only on or after done_o.
- In IDLE the register holds its last value indefinitely.

Test Plan:
1. Reset mid-run: start (mode 00, UNROLL=1), assert reset_i at cycle 5 → next cycle state_o=0, ready_o=1, done_o never pulses; a subsequent start completes normally.
2. Latency per mode: state_i=0, start with modes 00/01/10 → done_o high exactly 12/8/6 cycles after the start edge (UNROLL=1) and 6/4/3 cycles (UNROLL=2); ready_o=0 throughout RUN.
3. Golden vectors: state_i=0, and x0..x4 = 0x0123456789ABCDEF XOR k for k=0..4, all modes → state_o matches the reference C Ascon permutation bit-exactly. Both UNROLL builds give identical results.
4. Back-to-back: start asserted in the DONE cycle with new state_i and mode 10 → accepted with no IDLE cycle; second done_o 6 cycles later (UNROLL=1); first result visible on the first done_o.
5. Ignored start / reserved mode: start_i held high through RUN → exactly one operation per accepted start. mode_i=11 → 12-round latency and the same result as mode 00.
6. Round constant check: probe the counter sequence for mode 01 → constants 0xB4, 0xA5, 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B applied in order.
